// File: rtl/lap_counter_pkg.sv
// -----------------------------------------------------------------------------
// lap_counter_pkg
// Shared types and defaults for the lap counter and its prescaler.
//   dir_e        : count direction (DOWN / UP), driven from the 'up' input.
//   bound_mode_e : behaviour at the boundary (SATURATE / WRAP), from 'wrap'.
//   DEF_WIDTH    : default count/limit width.
//   DEF_PRE_WIDTH: default prescaler divisor width.
// -----------------------------------------------------------------------------
package lap_counter_pkg;

   localparam int DEF_WIDTH     = 8;
   localparam int DEF_PRE_WIDTH = 16;

   typedef enum logic {
      DOWN = 1'b0,
      UP   = 1'b1
   } dir_e;

   typedef enum logic {
      SATURATE = 1'b0,
      WRAP     = 1'b1
   } bound_mode_e;

endpackage : lap_counter_pkg

// File: rtl/lap_counter_if.sv
// -----------------------------------------------------------------------------
// lap_counter_if
// Control/status bundle of the lap counter.
//   master : controller side (drives clr/en/load/load_val/up/wrap/limit/
//            prescale, observes count/tick/tc/at_bound).
//   slave  : counter side (the opposite directions).
// -----------------------------------------------------------------------------
interface lap_counter_if #(
   parameter int WIDTH     = 8,
   parameter int PRE_WIDTH = 16
);

   logic                 clr;
   logic                 en;
   logic                 load;
   logic [WIDTH-1:0]     load_val;
   logic                 up;
   logic                 wrap;
   logic [WIDTH-1:0]     limit;
   logic [PRE_WIDTH-1:0] prescale;
   logic [WIDTH-1:0]     count;
   logic                 tick;
   logic                 tc;
   logic                 at_bound;

   modport master (
      output clr, en, load, load_val, up, wrap, limit, prescale,
      input  count, tick, tc, at_bound
   );

   modport slave (
      input  clr, en, load, load_val, up, wrap, limit, prescale,
      output count, tick, tc, at_bound
   );

endinterface : lap_counter_if

// File: rtl/lap_prescaler.sv
// -----------------------------------------------------------------------------
// lap_prescaler
// Divides enabled cycles: tick fires on every (prescale+1)-th enabled cycle.
// Ports:
//   clk      : system clock, rising edge.
//   rst_n    : asynchronous active-low reset.
//   en       : advances the prescaler; when low the phase is held.
//   restart  : synchronous restart (clear or load of the counter); also
//              suppresses tick in the same cycle.
//   prescale : divisor minus one.
//   tick     : combinational step strobe.
// -----------------------------------------------------------------------------
module lap_prescaler #(
   parameter int PRE_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 restart,
   input  logic [PRE_WIDTH-1:0] prescale,
   output logic                 tick
);

   logic [PRE_WIDTH-1:0] pre_cnt_q;
   logic [PRE_WIDTH-1:0] pre_cnt_d;

   // Lowering prescale below the running phase lets pre_cnt run on until it
   // wraps around; prescale is only meant to change while idle or cleared.
   always_comb begin
      tick      = en & ~restart & (pre_cnt_q == prescale);
      pre_cnt_d = pre_cnt_q;
      if (restart) begin
         pre_cnt_d = '0;
      end else if (tick) begin
         pre_cnt_d = '0;
      end else if (en) begin
         pre_cnt_d = pre_cnt_q + PRE_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt_q <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
      end
   end

endmodule : lap_prescaler

// File: rtl/lap_counter.sv
// -----------------------------------------------------------------------------
// lap_counter
// Prescaled up/down counter with programmable inclusive limit, wrap or
// saturate at the boundary, synchronous clear/load and a registered
// terminal-count pulse used to time light stages.
// Ports:
//   clk   : system clock, rising edge.
//   rst_n : asynchronous active-low reset (deassertion synchronised outside).
//   bus   : lap_counter_if.slave
//             clr, en, load, load_val, up, wrap, limit, prescale (inputs)
//             count    : current count
//             tick     : combinational step strobe
//             tc       : one-cycle pulse aligned with the count that reached
//                        the boundary
//             at_bound : count sits at the boundary for the current direction
// -----------------------------------------------------------------------------
module lap_counter
   import lap_counter_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int PRE_WIDTH = DEF_PRE_WIDTH
) (
   input  logic        clk,
   input  logic        rst_n,
   lap_counter_if.slave bus
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             tc_q;
   logic             tc_d;
   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] bound_val;
   logic             tick;
   dir_e             dir;
   bound_mode_e      mode;

   assign dir  = dir_e'(bus.up);
   assign mode = bound_mode_e'(bus.wrap);

   lap_prescaler #(
      .PRE_WIDTH (PRE_WIDTH)
   ) u_prescaler (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (bus.en),
      .restart  (bus.clr | bus.load),
      .prescale (bus.prescale),
      .tick     (tick)
   );

   always_comb begin
      bound_val = (dir == UP) ? bus.limit : '0;

      // Value the count would take if a step happens this cycle.
      step_val = count_q;
      if (dir == UP) begin
         if (count_q < bus.limit) begin
            step_val = count_q + WIDTH'(1);
         end else if (mode == WRAP) begin
            step_val = '0;
         end
      end else begin
         if (count_q != '0) begin
            step_val = count_q - WIDTH'(1);
         end else if (mode == WRAP) begin
            step_val = bus.limit;
         end
      end

      count_d = count_q;
      if (bus.clr) begin
         count_d = '0;
      end else if (bus.load) begin
         count_d = bus.load_val;
      end else if (tick) begin
         count_d = step_val;
      end

      // tick is already masked by clr/load, so tc clears on those too.
      // A saturating hold leaves the count unchanged and must not re-pulse;
      // in wrap mode an unchanged count (limit=0 going up) still pulses.
      tc_d = tick & (step_val == bound_val) &
             ((step_val != count_q) | (mode == WRAP));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   assign bus.count    = count_q;
   assign bus.tick     = tick;
   assign bus.tc       = tc_q;
   assign bus.at_bound = (dir == UP) ? (count_q >= bus.limit) : (count_q == '0);

endmodule : lap_counter

// File: doc/lap_counter.md
Name: lap_counter

Overview:
- Parametrised successor to the team's free-running enable counter, generalised for the starting-light sequencer's timing needs.
- Adds:
  - a built-in prescaler, so the count advances every PRESCALE+1 enabled cycles;
  - up/down direction;
  - a programmable limit with wrap or saturate mode;
  - synchronous clear and parallel load;
  - a registered terminal-count pulse.
- Sits between the system clock and the light FSM, which uses `tc` to time each light stage.

Parameters:
- WIDTH, 8: count and limit width in bits.
- PRE_WIDTH, 16: prescaler divisor width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of count, prescaler and tc.
- en  input  1  count enable; gates the prescaler.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value written to count on load.
- up  input  1  1 = count up, 0 = count down.
- wrap  input  1  1 = wrap at boundary, 0 = saturate.
- limit  input  WIDTH  upper bound, inclusive.
- prescale  input  PRE_WIDTH  divisor minus one; 0 means step on every enabled cycle.
- count  output  WIDTH  current count.
- tick  output  1  combinational step strobe.
- tc  output  1  registered terminal-count pulse.
- at_bound  output  1  combinational level: count is at the boundary.

Behaviour:
- Reset (rst_n low, asynchronous): count=0, internal pre_cnt=0, tc=0.
- Priority each clock edge: clr > load > step > hold.
- clr: count<=0, pre_cnt<=0, tc<=0.
- load (clr low): count<=load_val, pre_cnt<=0, tc<=0.
- Prescaler:
  - tick = en & ~clr & ~load & (pre_cnt==prescale).
  - On tick, pre_cnt<=0.
  - Else if en, pre_cnt<=pre_cnt+1.
  - Else pre_cnt holds.
  - If prescale is lowered below pre_cnt, pre_cnt keeps incrementing until it wraps modulo 2^PRE_WIDTH. This is an accepted hazard: change prescale only while en=0 or clr=1.
- Step on tick, up=1:
  - count<limit: count+1.
  - count>=limit: wrap=1 gives 0; wrap=0 gives hold.
- Step on tick, up=0:
  - count>0: count-1.
  - count==0: wrap=1 gives limit; wrap=0 gives hold at 0.
- Boundary value: limit when up=1, 0 when up=0.
- at_bound = up ? (count>=limit) : (count==0).
- tc:
  - Set for exactly one cycle after a step where count_next==boundary and (count_next!=count or wrap=1).
  - Otherwise 0.
  - Saturate hold produces no repeat pulses.
  - Degenerate case limit=0, up=1, wrap=1: count stays 0 and tc pulses on every step.
- Direction or mode changes take effect at the next tick; no extra latency.
- Latency:
  - count updates on the edge at which tick is high.
  - tc is high the cycle after that edge, aligned with the new count.
- Arithmetic is WIDTH-bit unsigned; no overflow beyond the limit/wrap rules.
- load_val>limit is legal:
  - up: the next step wraps or holds per the rules above.
  - down: decrements normally.
- rst_n asserted mid-count returns to reset values immediately. Deassertion must be synchronised externally.

Decomposition:
- Shared package lap_counter_pkg:
  - typedef enum dir_e {DOWN=0, UP=1};
  - typedef enum bound_mode_e {SATURATE=0, WRAP=1};
  - localparams for the default WIDTH and PRE_WIDTH.
- One sub-module: lap_prescaler (PRE_WIDTH parameter).
  - Inputs: clk, rst_n, en, restart(=clr|load), prescale.
  - Output: tick.
- Top level holds the count register, next-count logic and the tc register.

Test Plan:
- Reset/basic: rst_n low 3 cycles, then en=1, prescale=0, up=1, wrap=1, limit=5 -> count 0,1,2,3,4,5,0; tc high only the cycle count first reads 5.
- Prescaler: prescale=3, en=1 -> tick every 4th cycle, count increments once per 4 cycles; en dropped mid-period -> pre_cnt holds, phase resumes on re-enable.
- Saturate down: load_val=2, up=0, wrap=0 -> count 2,1,0,0,0; tc pulses once, on arrival at 0; at_bound=1 from then.
- Wrap down: limit=3, count=0, up=0, wrap=1, step -> count=3, tc=0; steps 3,2,1,0 -> single tc pulse on 0.
- Priority: clr, load and tick all high together -> count=0, tc=0; load and tick high together with load_val=7 -> count=7, pre_cnt=0.
- Async reset mid-run: count=4, prescaler mid-period, rst_n pulled low between edges -> count=0 and tc=0 immediately, with no clock edge needed.
